// File: rtl/pzcorebus_write_store_forward.sv
// ---------------------------------------------------------------------------
// pzcorebus_write_store_forward
//
// Store-and-forward request stage in front of the corebus upsizer. Write
// commands are held back until their whole data burst sits in the local data
// FIFO, so the downstream width converter sees gapless data bursts. READ and
// MESSAGE commands flow through in order with the writes; command order and
// data order are never changed.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and accept are both high. Valids are functions of registered state
// only and never depend on the accept of the same channel.
//
// Ports
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_scmd_*  / o_scmd_*    slave command channel  {command[1:0], payload}
//   i_sdata_* / o_sdata_*   slave data channel     {data, last}
//   o_mcmd_*  / i_mcmd_*    master command channel
//   o_mdata_* / i_mdata_*   master data channel
//   o_empty                 both FIFOs empty and both counters zero
//
// Parameters: COMMAND_DEPTH >= 1, DATA_DEPTH >= MAX_BURST_LENGTH.
// ---------------------------------------------------------------------------
module pzcorebus_write_store_forward #(
  parameter int COMMAND_WIDTH    = 64,
  parameter int DATA_WIDTH       = 32,
  parameter int COMMAND_DEPTH    = 4,
  parameter int DATA_DEPTH       = 16,
  parameter int MAX_BURST_LENGTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_scmd_valid,
  output logic                     o_scmd_accept,
  input  logic [1:0]               i_scmd_command,
  input  logic [COMMAND_WIDTH-1:0] i_scmd_payload,
  input  logic                     i_sdata_valid,
  output logic                     o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]    i_sdata_data,
  input  logic                     i_sdata_last,
  output logic                     o_mcmd_valid,
  input  logic                     i_mcmd_accept,
  output logic [1:0]               o_mcmd_command,
  output logic [COMMAND_WIDTH-1:0] o_mcmd_payload,
  output logic                     o_mdata_valid,
  input  logic                     i_mdata_accept,
  output logic [DATA_WIDTH-1:0]    o_mdata_data,
  output logic                     o_mdata_last,
  output logic                     o_empty
);

  localparam logic [1:0] CMD_READ     = 2'd0;
  localparam logic [1:0] CMD_WRITE    = 2'd1;
  localparam logic [1:0] CMD_WRITE_NP = 2'd2;

  localparam int CW  = COMMAND_WIDTH + 2;
  localparam int DW  = DATA_WIDTH + 1;
  localparam int CPW = (COMMAND_DEPTH > 1) ? $clog2(COMMAND_DEPTH) : 1;
  localparam int DPW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int CCW = $clog2(COMMAND_DEPTH + 1);
  localparam int DCW = $clog2(DATA_DEPTH + 1);
  localparam int BW  = $clog2(MAX_BURST_LENGTH + 1);

  // -------------------------------------------------------------------------
  // Command FIFO: {command, payload}
  // -------------------------------------------------------------------------
  logic [CW-1:0]  cmd_mem_q [COMMAND_DEPTH];
  logic [CPW-1:0] cmd_wr_ptr_q;
  logic [CPW-1:0] cmd_rd_ptr_q;
  logic [CCW-1:0] cmd_cnt_q;
  logic           cmd_full;
  logic           cmd_empty;
  logic           cmd_push;
  logic           cmd_pop;
  logic [CW-1:0]  cmd_head;
  logic           head_is_write;

  assign cmd_full      = (cmd_cnt_q == CCW'(COMMAND_DEPTH));
  assign cmd_empty     = (cmd_cnt_q == '0);
  assign cmd_push      = i_scmd_valid && !cmd_full;
  assign cmd_pop       = o_mcmd_valid && i_mcmd_accept;
  assign cmd_head      = cmd_mem_q[cmd_rd_ptr_q];
  assign head_is_write = (cmd_head[CW-1 -: 2] == CMD_WRITE) ||
                         (cmd_head[CW-1 -: 2] == CMD_WRITE_NP);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_cnt_q    <= '0;
      for (int i = 0; i < COMMAND_DEPTH; i++) cmd_mem_q[i] <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem_q[cmd_wr_ptr_q] <= {i_scmd_command, i_scmd_payload};
        cmd_wr_ptr_q <= (cmd_wr_ptr_q == CPW'(COMMAND_DEPTH - 1)) ? '0
                                                                  : cmd_wr_ptr_q + CPW'(1);
      end
      if (cmd_pop) begin
        cmd_rd_ptr_q <= (cmd_rd_ptr_q == CPW'(COMMAND_DEPTH - 1)) ? '0
                                                                  : cmd_rd_ptr_q + CPW'(1);
      end
      if (cmd_push && !cmd_pop)      cmd_cnt_q <= cmd_cnt_q + CCW'(1);
      else if (cmd_pop && !cmd_push) cmd_cnt_q <= cmd_cnt_q - CCW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Data FIFO: {data, last}
  // -------------------------------------------------------------------------
  logic [DW-1:0]  data_mem_q [DATA_DEPTH];
  logic [DPW-1:0] data_wr_ptr_q;
  logic [DPW-1:0] data_rd_ptr_q;
  logic [DCW-1:0] data_cnt_q;
  logic           data_full;
  logic           data_empty;
  logic           data_push;
  logic           data_pop;
  logic [DW-1:0]  data_head;

  assign data_full  = (data_cnt_q == DCW'(DATA_DEPTH));
  assign data_empty = (data_cnt_q == '0);
  assign data_push  = i_sdata_valid && !data_full;
  assign data_pop   = o_mdata_valid && i_mdata_accept;
  assign data_head  = data_mem_q[data_rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_wr_ptr_q <= '0;
      data_rd_ptr_q <= '0;
      data_cnt_q    <= '0;
      for (int i = 0; i < DATA_DEPTH; i++) data_mem_q[i] <= '0;
    end else begin
      if (data_push) begin
        data_mem_q[data_wr_ptr_q] <= {i_sdata_data, i_sdata_last};
        data_wr_ptr_q <= (data_wr_ptr_q == DPW'(DATA_DEPTH - 1)) ? '0
                                                                 : data_wr_ptr_q + DPW'(1);
      end
      if (data_pop) begin
        data_rd_ptr_q <= (data_rd_ptr_q == DPW'(DATA_DEPTH - 1)) ? '0
                                                                 : data_rd_ptr_q + DPW'(1);
      end
      if (data_push && !data_pop)      data_cnt_q <= data_cnt_q + DCW'(1);
      else if (data_pop && !data_push) data_cnt_q <= data_cnt_q - DCW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // burst_count: complete bursts buffered whose write command has not issued.
  // data_credit: issued write commands whose burst has not fully drained.
  // A write issue moves one unit from burst_count to data_credit, which is
  // what lets the next write command issue while the previous burst drains.
  // -------------------------------------------------------------------------
  logic [DCW-1:0] burst_count_q;
  logic [DCW-1:0] data_credit_q;
  logic           burst_inc;
  logic           burst_dec;
  logic           credit_inc;
  logic           credit_dec;

  assign burst_inc  = data_push && i_sdata_last;
  assign burst_dec  = cmd_pop && head_is_write;
  assign credit_inc = burst_dec;
  assign credit_dec = data_pop && data_head[0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      burst_count_q <= '0;
      data_credit_q <= '0;
    end else begin
      if (burst_inc && !burst_dec)      burst_count_q <= burst_count_q + DCW'(1);
      else if (burst_dec && !burst_inc) burst_count_q <= burst_count_q - DCW'(1);
      if (credit_inc && !credit_dec)      data_credit_q <= data_credit_q + DCW'(1);
      else if (credit_dec && !credit_inc) data_credit_q <= data_credit_q - DCW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Master side
  // -------------------------------------------------------------------------
  // A READ/MESSAGE head never waits for data; a write head waits for a
  // complete burst. Bursts are matched to write commands purely by order.
  assign o_mcmd_valid   = !cmd_empty && (!head_is_write || (burst_count_q != '0));
  assign o_mcmd_command = cmd_head[CW-1 -: 2];
  assign o_mcmd_payload = cmd_head[COMMAND_WIDTH-1:0];

  assign o_mdata_valid  = !data_empty && (data_credit_q != '0);
  assign o_mdata_data   = data_head[DW-1:1];
  assign o_mdata_last   = data_head[0];

  assign o_scmd_accept  = !cmd_full;
  assign o_sdata_accept = !data_full;

  assign o_empty = cmd_empty && data_empty &&
                   (burst_count_q == '0) && (data_credit_q == '0);

  // -------------------------------------------------------------------------
  // Burst-length tracking on the slave data side: number of beats of the
  // current (unfinished) burst already accepted, saturating at the maximum.
  // -------------------------------------------------------------------------
  logic [BW-1:0] sdata_beats_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sdata_beats_q <= '0;
    end else if (data_push) begin
      if (i_sdata_last)                                 sdata_beats_q <= '0;
      else if (sdata_beats_q != BW'(MAX_BURST_LENGTH)) sdata_beats_q <= sdata_beats_q + BW'(1);
    end
  end

  a_depth_covers_burst : assert property (@(posedge i_clk) DATA_DEPTH >= MAX_BURST_LENGTH);

  a_burst_length : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    data_push |-> (int'(sdata_beats_q) < MAX_BURST_LENGTH));

  a_burst_count_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(burst_dec && !burst_inc && (burst_count_q == '0)) &&
    !(burst_inc && !burst_dec && (burst_count_q == DCW'(DATA_DEPTH))));

  a_data_credit_range : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(credit_dec && !credit_inc && (data_credit_q == '0)) &&
    !(credit_inc && !credit_dec && (data_credit_q == DCW'(DATA_DEPTH))));

endmodule

// File: tb/tb_pzcorebus_write_store_forward.sv
// ---------------------------------------------------------------------------
// Testbench for pzcorebus_write_store_forward (default parameters).
// Expected commands and beats are queued when the slave side is driven and
// compared in order when the master side hands them out; cycle-exact timing
// of valids/accepts is checked inline in each scenario task.
// ---------------------------------------------------------------------------
module tb_pzcorebus_write_store_forward;

  localparam int CWID = 64;
  localparam int DWID = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            scmd_valid;
  logic            scmd_accept;
  logic [1:0]      scmd_command;
  logic [CWID-1:0] scmd_payload;
  logic            sdata_valid;
  logic            sdata_accept;
  logic [DWID-1:0] sdata_data;
  logic            sdata_last;
  logic            mcmd_valid;
  logic            mcmd_accept;
  logic [1:0]      mcmd_command;
  logic [CWID-1:0] mcmd_payload;
  logic            mdata_valid;
  logic            mdata_accept;
  logic [DWID-1:0] mdata_data;
  logic            mdata_last;
  logic            empty;

  int checks = 0;
  int errors = 0;

  logic [CWID+1:0] cmd_exp_q[$];
  logic [DWID:0]   data_exp_q[$];

  pzcorebus_write_store_forward dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_scmd_valid   (scmd_valid),
    .o_scmd_accept  (scmd_accept),
    .i_scmd_command (scmd_command),
    .i_scmd_payload (scmd_payload),
    .i_sdata_valid  (sdata_valid),
    .o_sdata_accept (sdata_accept),
    .i_sdata_data   (sdata_data),
    .i_sdata_last   (sdata_last),
    .o_mcmd_valid   (mcmd_valid),
    .i_mcmd_accept  (mcmd_accept),
    .o_mcmd_command (mcmd_command),
    .o_mcmd_payload (mcmd_payload),
    .o_mdata_valid  (mdata_valid),
    .i_mdata_accept (mdata_accept),
    .o_mdata_data   (mdata_data),
    .o_mdata_last   (mdata_last),
    .o_empty        (empty)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: master-side handshakes sampled on the falling edge
  always @(negedge clk) begin
    if (mcmd_valid && mcmd_accept) begin
      checks++;
      if (cmd_exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_cmd unexpected command got %h_%h exp none", mcmd_command, mcmd_payload);
      end else begin
        logic [CWID+1:0] e;
        e = cmd_exp_q.pop_front();
        if ({mcmd_command, mcmd_payload} !== e) begin
          errors++;
          $display("FAIL sb_cmd got %h exp %h", {mcmd_command, mcmd_payload}, e);
        end
      end
    end
    if (mdata_valid && mdata_accept) begin
      checks++;
      if (data_exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_data unexpected beat got %h/%b exp none", mdata_data, mdata_last);
      end else begin
        logic [DWID:0] e;
        e = data_exp_q.pop_front();
        if ({mdata_data, mdata_last} !== e) begin
          errors++;
          $display("FAIL sb_data got %h exp %h", {mdata_data, mdata_last}, e);
        end
      end
    end
  end

  // driver helpers: set a channel for the current cycle and queue expectation
  task automatic drive_cmd(input logic [1:0] c);
    scmd_valid   = 1'b1;
    scmd_command = c;
    scmd_payload = {$urandom, $urandom};
    cmd_exp_q.push_back({scmd_command, scmd_payload});
  endtask

  task automatic drive_beat(input logic last);
    sdata_valid = 1'b1;
    sdata_data  = $urandom;
    sdata_last  = last;
    data_exp_q.push_back({sdata_data, sdata_last});
  endtask

  task automatic idle_inputs;
    scmd_valid  = 1'b0;
    sdata_valid = 1'b0;
    sdata_last  = 1'b0;
  endtask

  task automatic check_drained(input string name);
    for (int i = 0; i < 4; i++) tick;
    checks++;
    if (empty !== 1'b1 || cmd_exp_q.size() != 0 || data_exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained empty=%b cmdq=%0d dataq=%0d exp 1/0/0",
               name, empty, cmd_exp_q.size(), data_exp_q.size());
    end
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    mcmd_accept  = 1'b1;
    mdata_accept = 1'b1;
    tick; tick;
    rst_n = 1'b1;
    checks++;
    if ({mcmd_valid, mdata_valid, scmd_accept, sdata_accept, empty} !== 5'b00111) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00111",
               {mcmd_valid, mdata_valid, scmd_accept, sdata_accept, empty});
    end
    checks++;
    if (mcmd_command !== 2'd0 || mcmd_payload !== '0 || mdata_data !== '0 || mdata_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %b exp zeros", mcmd_command, mcmd_payload,
               mdata_data, mdata_last);
    end
    tick;
  endtask

  // WRITE command, data starts two cycles later
  task automatic test_write_cmd_first;
    logic ev, ed;
    for (int c = 0; c < 12; c++) begin
      idle_inputs();
      if (c == 0) drive_cmd(2'd1);
      if (c >= 2 && c <= 5) drive_beat(c == 5);
      ev = (c == 6);
      ed = (c >= 7 && c <= 10);
      checks++;
      if (mcmd_valid !== ev) begin
        errors++;
        $display("FAIL wcf_mcmd_valid c=%0d got %b exp %b", c, mcmd_valid, ev);
      end
      checks++;
      if (mdata_valid !== ed || (ed && mdata_last !== (c == 10))) begin
        errors++;
        $display("FAIL wcf_mdata c=%0d got v%b l%b exp v%b l%b", c, mdata_valid, mdata_last,
                 ed, (c == 10));
      end
      tick;
    end
    idle_inputs();
    check_drained("wcf");
  endtask

  // 8-beat burst fully buffered, then its WRITE command
  task automatic test_data_first;
    logic ev, ed;
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      if (c <= 7) drive_beat(c == 7);
      if (c == 8) drive_cmd(2'd2);
      ev = (c == 9);
      ed = (c >= 10 && c <= 17);
      checks++;
      if (mcmd_valid !== ev) begin
        errors++;
        $display("FAIL dfirst_mcmd_valid c=%0d got %b exp %b", c, mcmd_valid, ev);
      end
      checks++;
      if (mdata_valid !== ed || (ed && mdata_last !== (c == 17))) begin
        errors++;
        $display("FAIL dfirst_mdata c=%0d got v%b l%b exp v%b l%b", c, mdata_valid, mdata_last,
                 ed, (c == 17));
      end
      tick;
    end
    idle_inputs();
    check_drained("dfirst");
  endtask

  // READ queued behind a WRITE whose data is late
  task automatic test_read_behind_write;
    logic ev, ed;
    for (int c = 0; c < 16; c++) begin
      idle_inputs();
      if (c == 0) drive_cmd(2'd1);
      if (c == 1) drive_cmd(2'd0);
      if (c == 10 || c == 11) drive_beat(c == 11);
      ev = (c == 12 || c == 13);
      ed = (c == 13 || c == 14);
      checks++;
      if (mcmd_valid !== ev || (c == 12 && mcmd_command !== 2'd1) ||
          (c == 13 && mcmd_command !== 2'd0)) begin
        errors++;
        $display("FAIL rbw_mcmd c=%0d got v%b t%0d exp v%b", c, mcmd_valid, mcmd_command, ev);
      end
      checks++;
      if (mdata_valid !== ed || (ed && mdata_last !== (c == 14))) begin
        errors++;
        $display("FAIL rbw_mdata c=%0d got v%b l%b exp v%b l%b", c, mdata_valid, mdata_last,
                 ed, (c == 14));
      end
      tick;
    end
    idle_inputs();
    check_drained("rbw");
  endtask

  // Two 8-beat bursts fill the data FIFO while the master stalls data
  task automatic test_backpressure_full;
    logic ea, ev, ed;
    for (int c = 0; c < 38; c++) begin
      idle_inputs();
      mdata_accept = (c >= 20);
      if (c <= 15) drive_beat(c == 7 || c == 15);
      if (c == 16 || c == 17) drive_cmd(2'd1);
      ea = !(c >= 16 && c <= 20);
      ev = (c == 17 || c == 18);
      ed = (c >= 18 && c <= 35);
      if (c <= 20) begin
        checks++;
        if (sdata_accept !== ea) begin
          errors++;
          $display("FAIL bp_sdata_accept c=%0d got %b exp %b", c, sdata_accept, ea);
        end
      end
      if (c == 16) begin
        checks++;
        if (dut.burst_count_q !== 5'd2) begin
          errors++;
          $display("FAIL bp_burst_count got %0d exp 2", dut.burst_count_q);
        end
      end
      checks++;
      if (mcmd_valid !== ev) begin
        errors++;
        $display("FAIL bp_mcmd_valid c=%0d got %b exp %b", c, mcmd_valid, ev);
      end
      checks++;
      if (mdata_valid !== ed || (c >= 20 && ed && mdata_last !== (c == 27 || c == 35))) begin
        errors++;
        $display("FAIL bp_mdata c=%0d got v%b l%b exp v%b", c, mdata_valid, mdata_last, ed);
      end
      tick;
    end
    idle_inputs();
    mdata_accept = 1'b1;
    check_drained("bp");
  endtask

  // Counter increment and decrement landing on the same edge
  task automatic test_simultaneous;
    int exp_bc[6] = '{0, 1, 1, 1, 0, 0};
    int exp_cr[6] = '{0, 0, 1, 1, 1, 0};
    logic ev, ed;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c <= 2) begin
        drive_cmd(2'd1);
        drive_beat(1'b1);
      end
      ev = (c >= 1 && c <= 3);
      ed = (c >= 2 && c <= 4);
      checks++;
      if (int'(dut.burst_count_q) != exp_bc[c] || int'(dut.data_credit_q) != exp_cr[c]) begin
        errors++;
        $display("FAIL simul_counters c=%0d got bc%0d cr%0d exp bc%0d cr%0d", c,
                 dut.burst_count_q, dut.data_credit_q, exp_bc[c], exp_cr[c]);
      end
      checks++;
      if (mcmd_valid !== ev || mdata_valid !== ed) begin
        errors++;
        $display("FAIL simul_valids c=%0d got %b%b exp %b%b", c, mcmd_valid, mdata_valid, ev, ed);
      end
      tick;
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty got %b exp 1", empty);
    end
    check_drained("simul");
  endtask

  // Reset after 3 of 8 beats drops everything buffered
  task automatic test_reset_mid_burst;
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      if (c == 0) drive_cmd(2'd1);
      drive_beat(1'b0);
      tick;
    end
    idle_inputs();
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL rmid_not_empty got %b exp 0", empty);
    end
    rst_n = 1'b0;
    tick;
    cmd_exp_q.delete();
    data_exp_q.delete();
    checks++;
    if ({mcmd_valid, mdata_valid, scmd_accept, sdata_accept, empty} !== 5'b00111) begin
      errors++;
      $display("FAIL rmid_flags got %b exp 00111",
               {mcmd_valid, mdata_valid, scmd_accept, sdata_accept, empty});
    end
    checks++;
    if (mcmd_payload !== '0 || mdata_data !== '0 || mdata_last !== 1'b0 ||
        dut.burst_count_q !== '0) begin
      errors++;
      $display("FAIL rmid_data got %h %h %b bc%0d exp zeros", mcmd_payload, mdata_data,
               mdata_last, dut.burst_count_q);
    end
    rst_n = 1'b1;
    tick;
  endtask

  // Random mix of commands and bursts with random master stalls
  task automatic test_random;
    logic [1:0] cmds[12];
    int         lens[12];
    for (int i = 0; i < 12; i++) begin
      cmds[i] = 2'($urandom_range(0, 3));
      lens[i] = $urandom_range(1, 8);
    end
    fork
      begin : cmd_drv
        for (int i = 0; i < 12; i++) begin
          int w;
          scmd_valid   = 1'b1;
          scmd_command = cmds[i];
          scmd_payload = {$urandom, $urandom};
          w = 0;
          while (!scmd_accept && w < 300) begin tick; w++; end
          cmd_exp_q.push_back({scmd_command, scmd_payload});
          tick;
          scmd_valid = 1'b0;
          repeat ($urandom_range(0, 3)) tick;
        end
      end
      begin : data_drv
        for (int i = 0; i < 12; i++) begin
          if (cmds[i] == 2'd1 || cmds[i] == 2'd2) begin
            for (int b = 0; b < lens[i]; b++) begin
              int w;
              sdata_valid = 1'b1;
              sdata_data  = $urandom;
              sdata_last  = (b == lens[i] - 1);
              w = 0;
              while (!sdata_accept && w < 300) begin tick; w++; end
              data_exp_q.push_back({sdata_data, sdata_last});
              tick;
              sdata_valid = 1'b0;
              if ($urandom_range(0, 3) == 0) tick;
            end
          end
        end
      end
      begin : sink
        for (int k = 0; k < 250; k++) begin
          mcmd_accept  = ($urandom_range(0, 3) != 0);
          mdata_accept = ($urandom_range(0, 3) != 0);
          tick;
        end
        mcmd_accept  = 1'b1;
        mdata_accept = 1'b1;
      end
    join
    idle_inputs();
    for (int w = 0; w < 200 && !empty; w++) tick;
    check_drained("rand");
  endtask

  initial begin
    rst_n        = 1'b0;
    scmd_valid   = 1'b0;
    scmd_command = 2'd0;
    scmd_payload = '0;
    sdata_valid  = 1'b0;
    sdata_data   = '0;
    sdata_last   = 1'b0;
    mcmd_accept  = 1'b1;
    mdata_accept = 1'b1;
    tick; tick;

    test_reset();
    test_write_cmd_first();
    test_data_first();
    test_read_behind_write();
    test_backpressure_full();
    test_simultaneous();
    test_reset_mid_burst();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
